// File: rtl/fetch_controller_pkg.sv
// Shared types and helpers for the fetch front end: FSM states, line alignment
// and the sizing of the prefetch look-ahead counter.
package fetch_controller_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;

   // Generic 64-bit form; callers cast to their own address width.
   function automatic logic [63:0] line_of(input logic [63:0] addr, input int unsigned line_bytes);
      return addr & ~(64'(line_bytes) - 64'd1);
   endfunction

   function automatic int unsigned ahead_w(input int unsigned depth);
      return $clog2(depth + 2);
   endfunction

endpackage

// File: rtl/fetch_prefetch_window.sv
// Line-granular prefetch pointer running up to PREFETCH_DEPTH lines ahead of the PC line.
// Request is combinational, held until acked; pointer only moves while rdy is high.
module fetch_prefetch_window
   import fetch_controller_pkg::*;
#(
   parameter int                XLEN           = 32,
   parameter logic [XLEN-1:0]   RESET_PC       = '0,
   parameter int                LINE_BYTES     = 16,
   parameter int                PREFETCH_DEPTH = 2
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            active,
   input  logic            run,
   input  logic            redirect_valid,
   input  logic            load,
   input  logic [XLEN-1:0] load_addr,
   input  logic [XLEN-1:0] pc,
   input  logic            prefetch_ack,
   output logic [XLEN-1:0] prefetch_PC,
   output logic            is_prefetching
);

   localparam int              AW      = ahead_w(PREFETCH_DEPTH);
   localparam int              LB_LOG2 = $clog2(LINE_BYTES);
   localparam logic [XLEN-1:0] LB      = XLEN'(LINE_BYTES);
   localparam logic [XLEN-1:0] PF_RST  = XLEN'(line_of(64'(RESET_PC), LINE_BYTES)) + LB;

   logic [XLEN-1:0] pf_ptr;
   logic [XLEN-1:0] pc_line;
   logic [XLEN-1:0] load_line;
   logic [XLEN-1:0] diff;
   logic [AW-1:0]   ahead;

   assign pc_line   = XLEN'(line_of(64'(pc), LINE_BYTES));
   assign load_line = XLEN'(line_of(64'(load_addr), LINE_BYTES));

   // Modulo subtraction keeps the distance correct across the 2^XLEN wrap;
   // anything beyond the window saturates so the narrow counter never aliases.
   assign diff  = (pf_ptr - pc_line) >> LB_LOG2;
   assign ahead = (diff > XLEN'(PREFETCH_DEPTH + 1)) ? AW'(PREFETCH_DEPTH + 1) : diff[AW-1:0];

   assign prefetch_PC    = pf_ptr;
   assign is_prefetching = active & run & ~redirect_valid & (ahead <= AW'(PREFETCH_DEPTH));

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pf_ptr <= PF_RST;
      end else if (active) begin
         if (load)
            pf_ptr <= load_line + LB;
         else if (is_prefetching & prefetch_ack)
            pf_ptr <= pf_ptr + LB;
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, issues one instruction per cycle, flushes on redirect, halts on request.
// Redirect lands one cycle later with a one-cycle flush pulse; rdy_in low freezes all state and outputs.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter logic [XLEN-1:0] RESET_PC       = '0,
   parameter int              LINE_BYTES     = 16,
   parameter int              PREFETCH_DEPTH = 2,
   parameter int              ILEN_BYTES     = 4
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic            inst_valid,
   input  logic            issue_ready,
   input  logic            pred_taken,
   input  logic [XLEN-1:0] pred_target,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt_req,
   input  logic            prefetch_ack,
   output logic            flush_pipline,
   output logic [XLEN-1:0] nxt_PC,
   output logic            is_issuing,
   output logic [XLEN-1:0] prefetch_PC,
   output logic            is_prefetching,
   output logic            halted
);

   state_t          state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic            flush_q, flush_nxt;
   logic            active;
   logic            pf_load;
   logic [XLEN-1:0] pf_load_addr;

   // Outputs also drop while reset is held, not just after the next edge.
   assign active = rdy_in & ~rst_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state   <= RUN;
         pc      <= RESET_PC;
         flush_q <= 1'b0;
      end else if (rdy_in) begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         flush_q <= flush_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      flush_nxt    = 1'b0;
      is_issuing   = 1'b0;
      pf_load      = 1'b0;
      pf_load_addr = pc;
      if (active) begin
         unique case (state)
            RUN, FLUSH: begin
               if (redirect_valid) begin
                  state_nxt    = FLUSH;
                  pc_nxt       = redirect_pc;
                  flush_nxt    = 1'b1;
                  pf_load      = 1'b1;
                  pf_load_addr = redirect_pc;
               end else begin
                  if (state == RUN) begin
                     is_issuing = inst_valid & issue_ready;
                     if (is_issuing) begin
                        pc_nxt = pred_taken ? pred_target : pc + XLEN'(ILEN_BYTES);
                        if (pred_taken) begin
                           pf_load      = 1'b1;
                           pf_load_addr = pred_target;
                        end
                     end
                  end
                  state_nxt = halt_req ? HALT : RUN;
               end
            end
            default: ;
         endcase
      end
   end

   assign nxt_PC        = pc;
   assign flush_pipline = flush_q & active;
   assign halted        = (state == HALT);

   fetch_prefetch_window #(
      .XLEN           (XLEN),
      .RESET_PC       (RESET_PC),
      .LINE_BYTES     (LINE_BYTES),
      .PREFETCH_DEPTH (PREFETCH_DEPTH)
   ) u_window (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .active         (active),
      .run            (state == RUN),
      .redirect_valid (redirect_valid),
      .load           (pf_load),
      .load_addr      (pf_load_addr),
      .pc             (pc),
      .prefetch_ack   (prefetch_ack),
      .prefetch_PC    (prefetch_PC),
      .is_prefetching (is_prefetching)
   );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with default parameters (LINE_BYTES=16, DEPTH=2).
module tb_fetch_controller;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        inst_valid;
   logic        issue_ready;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        prefetch_ack;
   logic        flush_pipline;
   logic [31:0] nxt_PC;
   logic        is_issuing;
   logic [31:0] prefetch_PC;
   logic        is_prefetching;
   logic        halted;

   int n_cmp = 0;
   int n_err = 0;

   fetch_controller dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .inst_valid     (inst_valid),
      .issue_ready    (issue_ready),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .prefetch_ack   (prefetch_ack),
      .flush_pipline  (flush_pipline),
      .nxt_PC         (nxt_PC),
      .is_issuing     (is_issuing),
      .prefetch_PC    (prefetch_PC),
      .is_prefetching (is_prefetching),
      .halted         (halted)
   );

   always #5 clk_in = ~clk_in;

   // Leaves the bench 1 time unit after a rising edge; inputs change here.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      rdy_in = 1'b1; inst_valid = 1'b0; issue_ready = 1'b0; pred_taken = 1'b0;
      pred_target = '0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
      prefetch_ack = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      inst_valid = 1'b1; issue_ready = 1'b1;
      rst_in = 1'b1;
      #2;
      n_cmp++; if (nxt_PC !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", nxt_PC, 32'h0); end
      n_cmp++; if ({flush_pipline, is_issuing, is_prefetching, halted} !== 4'b0000) begin
         n_err++; $display("FAIL reset_outs got %b want 0000", {flush_pipline, is_issuing, is_prefetching, halted}); end
      step();
      rst_in = 1'b0;
      #2;
      n_cmp++; if (prefetch_PC !== 32'h10) begin n_err++; $display("FAIL reset_pf got %h want %h", prefetch_PC, 32'h10); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (nxt_PC !== 32'(4 * i) || is_issuing !== 1'b1) begin
            n_err++; $display("FAIL seq_issue[%0d] got pc=%h iss=%b want pc=%h iss=1", i, nxt_PC, is_issuing, 32'(4 * i)); end
         step();
      end
   endtask

   task automatic test_prefetch_window();
      logic [31:0] exp_pf [3];
      logic        exp_v  [3];
      exp_pf = '{32'h10, 32'h20, 32'h30};
      exp_v  = '{1'b1, 1'b1, 1'b0};
      do_reset();
      inst_valid = 1'b1; prefetch_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         n_cmp++; if (prefetch_PC !== exp_pf[i] || is_prefetching !== exp_v[i]) begin
            n_err++; $display("FAIL pf_window[%0d] got %h/%b want %h/%b", i, prefetch_PC, is_prefetching, exp_pf[i], exp_v[i]); end
         step();
      end
      issue_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      #2;
      n_cmp++; if (nxt_PC !== 32'h10 || prefetch_PC !== 32'h30 || is_prefetching !== 1'b1) begin
         n_err++; $display("FAIL pf_release got pc=%h pf=%h v=%b want 10/30/1", nxt_PC, prefetch_PC, is_prefetching); end
   endtask

   task automatic test_pred_taken();
      do_reset();
      inst_valid = 1'b1; issue_ready = 1'b1;
      step(); step();
      pred_taken = 1'b1; pred_target = 32'h100;
      #2;
      n_cmp++; if (nxt_PC !== 32'h8 || is_issuing !== 1'b1) begin
         n_err++; $display("FAIL taken_pre got pc=%h iss=%b want 8/1", nxt_PC, is_issuing); end
      step();
      pred_taken = 1'b0;
      #2;
      n_cmp++; if (nxt_PC !== 32'h100 || prefetch_PC !== 32'h110 || is_prefetching !== 1'b1) begin
         n_err++; $display("FAIL taken_post got pc=%h pf=%h v=%b want 100/110/1", nxt_PC, prefetch_PC, is_prefetching); end
   endtask

   task automatic test_redirect();
      do_reset();
      inst_valid = 1'b1; issue_ready = 1'b1; prefetch_ack = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h2000;
      #2;
      n_cmp++; if ({is_issuing, is_prefetching, flush_pipline} !== 3'b000) begin
         n_err++; $display("FAIL redir_same got %b want 000", {is_issuing, is_prefetching, flush_pipline}); end
      step();
      redirect_valid = 1'b0;
      #2;
      n_cmp++; if (flush_pipline !== 1'b1 || nxt_PC !== 32'h2000 || is_issuing !== 1'b0 || is_prefetching !== 1'b0) begin
         n_err++; $display("FAIL redir_flush got fl=%b pc=%h iss=%b pf=%b want 1/2000/0/0", flush_pipline, nxt_PC, is_issuing, is_prefetching); end
      step();
      #2;
      n_cmp++; if (flush_pipline !== 1'b0 || is_issuing !== 1'b1 || prefetch_PC !== 32'h2010) begin
         n_err++; $display("FAIL redir_resume got fl=%b iss=%b pf=%h want 0/1/2010", flush_pipline, is_issuing, prefetch_PC); end
      step();
      #2;
      n_cmp++; if (nxt_PC !== 32'h2004) begin n_err++; $display("FAIL redir_next got %h want 2004", nxt_PC); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      inst_valid = 1'b1; issue_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'h3000;
      step();
      redirect_pc = 32'h4000;
      #2;
      n_cmp++; if (flush_pipline !== 1'b1 || nxt_PC !== 32'h3000) begin
         n_err++; $display("FAIL b2b_first got fl=%b pc=%h want 1/3000", flush_pipline, nxt_PC); end
      step();
      redirect_valid = 1'b0;
      #2;
      n_cmp++; if (flush_pipline !== 1'b1 || nxt_PC !== 32'h4000) begin
         n_err++; $display("FAIL b2b_second got fl=%b pc=%h want 1/4000", flush_pipline, nxt_PC); end
      step();
      #2;
      n_cmp++; if (flush_pipline !== 1'b0 || is_issuing !== 1'b1) begin
         n_err++; $display("FAIL b2b_end got fl=%b iss=%b want 0/1", flush_pipline, is_issuing); end
   endtask

   task automatic test_rdy_stall();
      do_reset();
      inst_valid = 1'b1; issue_ready = 1'b1; prefetch_ack = 1'b1;
      step(); step();
      rdy_in = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
      for (int i = 0; i < 5; i++) begin
         #2;
         n_cmp++; if (nxt_PC !== 32'h8 || {is_issuing, is_prefetching, flush_pipline} !== 3'b000) begin
            n_err++; $display("FAIL stall[%0d] got pc=%h outs=%b want 8/000", i, nxt_PC, {is_issuing, is_prefetching, flush_pipline}); end
         step();
      end
      rdy_in = 1'b1;
      #2;
      n_cmp++; if (is_issuing !== 1'b0 || nxt_PC !== 32'h8) begin
         n_err++; $display("FAIL stall_release got iss=%b pc=%h want 0/8", is_issuing, nxt_PC); end
      step();
      redirect_valid = 1'b0;
      #2;
      n_cmp++; if (flush_pipline !== 1'b1 || nxt_PC !== 32'h500) begin
         n_err++; $display("FAIL stall_redir got fl=%b pc=%h want 1/500", flush_pipline, nxt_PC); end
   endtask

   task automatic test_wrap_halt();
      do_reset();
      inst_valid = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFE8;
      step();
      redirect_valid = 1'b0;
      step();
      prefetch_ack = 1'b1;
      #2;
      n_cmp++; if (prefetch_PC !== 32'hFFFF_FFF0 || is_prefetching !== 1'b1) begin
         n_err++; $display("FAIL wrap_pf0 got %h/%b want fffffff0/1", prefetch_PC, is_prefetching); end
      step();
      #2;
      n_cmp++; if (prefetch_PC !== 32'h0 || is_prefetching !== 1'b1) begin
         n_err++; $display("FAIL wrap_pf1 got %h/%b want 0/1", prefetch_PC, is_prefetching); end
      step();
      #2;
      n_cmp++; if (prefetch_PC !== 32'h10 || is_prefetching !== 1'b0) begin
         n_err++; $display("FAIL wrap_pf_block got %h/%b want 10/0", prefetch_PC, is_prefetching); end
      prefetch_ack = 1'b0; issue_ready = 1'b1;
      step(); step();
      #2;
      n_cmp++; if (nxt_PC !== 32'hFFFF_FFF0 || is_prefetching !== 1'b1) begin
         n_err++; $display("FAIL wrap_pf_release got pc=%h v=%b want fffffff0/1", nxt_PC, is_prefetching); end
      step(); step(); step();
      #2;
      n_cmp++; if (nxt_PC !== 32'hFFFF_FFFC || is_issuing !== 1'b1) begin
         n_err++; $display("FAIL wrap_last got pc=%h iss=%b want fffffffc/1", nxt_PC, is_issuing); end
      step();
      issue_ready = 1'b0;
      #2;
      n_cmp++; if (nxt_PC !== 32'h0 || prefetch_PC !== 32'h10 || is_prefetching !== 1'b1) begin
         n_err++; $display("FAIL wrap_pc got pc=%h pf=%h v=%b want 0/10/1", nxt_PC, prefetch_PC, is_prefetching); end
      halt_req = 1'b1;
      step();
      halt_req = 1'b0; issue_ready = 1'b1;
      #2;
      n_cmp++; if (halted !== 1'b1 || is_issuing !== 1'b0 || is_prefetching !== 1'b0) begin
         n_err++; $display("FAIL halt got h=%b iss=%b pf=%b want 1/0/0", halted, is_issuing, is_prefetching); end
      redirect_valid = 1'b1; redirect_pc = 32'h700;
      step();
      redirect_valid = 1'b0;
      #2;
      n_cmp++; if (halted !== 1'b1 || nxt_PC !== 32'h0 || flush_pipline !== 1'b0) begin
         n_err++; $display("FAIL halt_redir got h=%b pc=%h fl=%b want 1/0/0", halted, nxt_PC, flush_pipline); end
      rst_in = 1'b1;
      #2;
      n_cmp++; if (halted !== 1'b0 || is_issuing !== 1'b0 || prefetch_PC !== 32'h10) begin
         n_err++; $display("FAIL async_reset got h=%b iss=%b pf=%h want 0/0/10", halted, is_issuing, prefetch_PC); end
      step();
      rst_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_prefetch_window();
      test_pred_taken();
      test_redirect();
      test_back_to_back();
      test_rdy_stall();
      test_wrap_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout compared=%0d", n_cmp);
      $fatal(1, "timeout");
   end

endmodule
